count_sequence_monitor: RTL and testbench
=========================================

// Module: count_sequence_monitor
// PURPOSE
//  Receive-side checker for a free-running binary up-counter bus (e.g. twobitCounter 'out').
//  Samples the bus every enabled clock and locks onto a legal +1 (mod 2^W) sequence.
//  Reports wrap-arounds, counts sequence errors and flags loss of lock.
//  Sits downstream of any counter in the design, as an in-circuit monitor and a bench scoreboard.
// PARAMETERS
//  W           2  width of monitored count bus
//  LOCK_COUNT  4  consecutive good steps needed to enter LOCKED (>=1)
//  CNT_W       8  width of wrap_count and err_count (saturating)
// PORTS
//  clk         in   1      single clock, rising-edge
//  rst         in   1      reset, asynchronous, active-high
//  en          in   1      sample enable; 0 = freeze all state, no pulses
//  cnt_in      in   W      counter value under observation
//  clr_err     in   1      synchronous clear of err_sticky
//  locked      out  1      1 while FSM is in LOCKED
//  wrap_pulse  out  1      one-cycle pulse: wrap (2^W-1 -> 0) seen while LOCKED
//  err_pulse   out  1      one-cycle pulse: bad step seen while LOCKED
//  err_sticky  out  1      set by err_pulse condition, cleared by clr_err
//  wrap_count  out  CNT_W  number of wraps seen while LOCKED, saturating
//  err_count   out  CNT_W  number of errors, saturating
// BEHAVIOUR
//  - Reset: state=IDLE, prev=0, run=0; every output 0. Asynchronous: takes effect
//    immediately, including mid-LOCKED. No clock edge is needed.
//  - All outputs are registered. A sample taken at edge k is reflected right after edge k.
//  - en=0: state, prev, run and counters hold; wrap_pulse and err_pulse are 0.
//    clr_err is still honoured.
//  - good step: cnt_in == prev+1 mod 2^W. Any other value, including a hold, is a bad step.
//  - FSM, evaluated only when en=1:
//    IDLE:   prev<=cnt_in; run<=0; ->SYNC.
//    SYNC:   good: run<=run+1; if run+1==LOCK_COUNT ->LOCKED, run<=0.
//            bad: run<=0, stay SYNC, no error reported. prev<=cnt_in always.
//    LOCKED: good: stay; if prev==2^W-1 && cnt_in==0 then wrap_pulse=1, wrap_count+1.
//            bad: err_pulse=1, err_sticky=1, err_count+1, ->SYNC, run<=0.
//            prev<=cnt_in always.
//  - Wraps observed in SYNC are not counted.
//  - Counters saturate at 2^CNT_W-1 and never roll over.
//  - err set and clr_err in the same cycle: set wins, err_sticky stays 1.
//  - locked deasserts on the same edge that err_pulse asserts.
// STRUCTURE
//  - Shared defs header/package count_mon_pkg holds the state encoding
//    (IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2) and the saturating-increment function.
//  - Sub-module sat_counter #(CNT_W) (clk, rst, inc, q), instantiated twice
//    (wrap_count, err_count).
//  - Remainder: one FSM always block plus a registered output block.
// TESTING (W=2, LOCK_COUNT=4, CNT_W=8, clk period 200, rst high for first 200)
//  1. en=1, cnt_in 0,1,2,3,0 -> locked=1 after 5th sample, wrap_count=0.
//     Continue 1,2,3,0 -> wrap_pulse for exactly 1 cycle, wrap_count=1.
//  2. LOCKED at 0, then inject 2 -> err_pulse 1 cycle, err_sticky=1, err_count=1, locked=0.
//     Then 3,0,1,2 -> locked=1 again.
//  3. LOCKED, en=0 for 3 cycles while cnt_in changes arbitrarily -> no output change.
//     en=1 with the next legal value -> stays locked, no err.
//  4. Assert rst asynchronously mid-LOCKED between edges -> all outputs 0 before next edge.
//     FSM restarts from IDLE.
//  5. clr_err=1 on the same edge as a bad step -> err_sticky=1.
//     clr_err=1 alone on the next edge -> err_sticky=0.
//  6. CNT_W=2 build, 5 wraps while LOCKED -> wrap_count=3 and holds; wrap_pulse still fires each wrap.

Source files
------------

// File: rtl/count_sequence_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : count_mon_pkg
//  Purpose  : Shared state encoding and saturating-increment helper for the
//             count sequence monitor.
//  Revision : 1.0  initial release
// ============================================================================
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Increment val, clamping at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max;
    max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max) ? max : (val + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_sequence_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Event counter that sticks at its maximum value.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter
  import count_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc) begin
      q <= CNT_W'(sat_inc(32'(q), CNT_W));
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_sequence_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : count_sequence_monitor
//  Purpose  : Locks onto a +1 (mod 2^W) counter stream and reports wraps,
//             sequence errors and loss of lock.
//  Revision : 1.0  initial release
// ============================================================================
module count_sequence_monitor
  import count_mon_pkg::*;
#(
  parameter int W          = 2,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     cnt_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int c_run_w = $clog2(LOCK_COUNT + 1);

  state_t             r_state;
  logic [W-1:0]       r_prev;
  logic [c_run_w-1:0] r_run;

  logic [W-1:0]       w_prev_inc;
  logic [c_run_w-1:0] w_run_inc;
  logic               w_good;
  logic               w_run_done;
  logic               w_wrap_ev;
  logic               w_err_ev;

  assign w_prev_inc = r_prev + W'(1);
  assign w_good     = (cnt_in == w_prev_inc);
  assign w_run_inc  = r_run + c_run_w'(1);
  assign w_run_done = (w_run_inc == c_run_w'(LOCK_COUNT));

  // A good step landing on zero can only come from the all-ones value.
  assign w_wrap_ev  = en && (r_state == LOCKED) && w_good && (cnt_in == '0);
  assign w_err_ev   = en && (r_state == LOCKED) && !w_good;

  assign locked     = (r_state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_run   <= '0;
    end else if (en) begin
      r_prev <= cnt_in;
      case (r_state)
        IDLE: begin
          r_run   <= '0;
          r_state <= SYNC;
        end
        SYNC: begin
          if (w_good) begin
            if (w_run_done) begin
              r_run   <= '0;
              r_state <= LOCKED;
            end else begin
              r_run <= w_run_inc;
            end
          end else begin
            r_run <= '0;
          end
        end
        LOCKED: begin
          if (!w_good) begin
            r_run   <= '0;
            r_state <= SYNC;
          end
        end
        default: begin
          r_run   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Setting the sticky flag takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wrap_pulse <= w_wrap_ev;
      err_pulse  <= w_err_ev;
      if (w_err_ev) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_wrap_ev),
    .q   (wrap_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_err_ev),
    .q   (err_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_count_sequence_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_sequence_monitor
//  Purpose  : Directed and random checks of count_sequence_monitor against a
//             streak-based reference model; second instance uses CNT_W=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_count_sequence_monitor;

  localparam int LOCK_COUNT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] cnt_in = 2'd0;
  logic       clr_err = 1'b0;

  logic       locked, wrap_pulse, err_pulse, err_sticky;
  logic [7:0] wrap_count, err_count;
  logic       locked2, wrap_pulse2, err_pulse2, err_sticky2;
  logic [1:0] wrap_count2, err_count2;

  int tests = 0;
  int fails = 0;

  // Reference model: locked means the current run of good steps is long enough.
  bit m_have = 0;
  int m_prev = 0;
  int m_streak = 0;
  int m_wraps = 0;
  int m_errs = 0;
  bit m_sticky = 0;
  bit m_wp = 0;
  bit m_ep = 0;

  always #100 clk = ~clk;

  count_sequence_monitor #(.W(2), .LOCK_COUNT(LOCK_COUNT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr_err(clr_err),
    .locked(locked), .wrap_pulse(wrap_pulse), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .wrap_count(wrap_count), .err_count(err_count)
  );

  count_sequence_monitor #(.W(2), .LOCK_COUNT(LOCK_COUNT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr_err(clr_err),
    .locked(locked2), .wrap_pulse(wrap_pulse2), .err_pulse(err_pulse2),
    .err_sticky(err_sticky2), .wrap_count(wrap_count2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_streak = 0; m_wraps = 0; m_errs = 0;
    m_sticky = 0; m_wp = 0; m_ep = 0;
  endtask

  task automatic model_step(input bit e, input int c, input bit clr);
    bit good;
    m_wp = 0;
    m_ep = 0;
    if (e) begin
      if (!m_have) begin
        m_have = 1;
        m_streak = 0;
      end else begin
        good = (c == (m_prev + 1) % 4);
        if (good) begin
          if (m_streak >= LOCK_COUNT && c == 0) begin
            m_wp = 1;
            m_wraps++;
          end
          if (m_streak < 1000) m_streak++;
        end else begin
          if (m_streak >= LOCK_COUNT) begin
            m_ep = 1;
            m_errs++;
          end
          m_streak = 0;
        end
      end
      m_prev = c;
    end
    if (m_ep) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_all();
    chk("locked", 32'(locked), 32'(m_streak >= LOCK_COUNT));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wp));
    chk("err_pulse", 32'(err_pulse), 32'(m_ep));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("wrap_count", 32'(wrap_count), 32'(sat(m_wraps, 255)));
    chk("err_count", 32'(err_count), 32'(sat(m_errs, 255)));
    chk("wrap_count2", 32'(wrap_count2), 32'(sat(m_wraps, 3)));
    chk("err_count2", 32'(err_count2), 32'(sat(m_errs, 3)));
  endtask

  task automatic step(input bit e, input int c, input bit clr);
    @(negedge clk);
    en = e;
    cnt_in = 2'(c);
    clr_err = clr;
    @(posedge clk);
    model_step(e, c, clr);
    #1 check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_wrap_pulse"}, 32'(wrap_pulse), 32'd0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
    chk({tag, "_wrap_count"}, 32'(wrap_count), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_locked2"}, 32'(locked2), 32'd0);
    chk({tag, "_wrap_count2"}, 32'(wrap_count2), 32'd0);
  endtask

  initial begin
    int seq1 [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int npulse;
    int c;
    bit e, clr;

    // Reset state
    #150 check_zero("reset");
    #50 rst = 1'b0;

    // 1: lock, then a wrap while locked
    for (int i = 0; i < 9; i++) begin
      step(1, seq1[i], 0);
      if (i == 4) begin
        chk("t1_locked_after5", 32'(locked), 32'd1);
        chk("t1_no_wrap_in_sync", 32'(wrap_count), 32'd0);
      end
    end
    chk("t1_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t1_wrap_count", 32'(wrap_count), 32'd1);

    // 2: bad step while locked, then relock
    step(1, 2, 0);
    chk("t2_wrap_pulse_one_cycle", 32'(wrap_pulse), 32'd0);
    chk("t2_err_pulse", 32'(err_pulse), 32'd1);
    chk("t2_locked_drop", 32'(locked), 32'd0);
    chk("t2_err_count", 32'(err_count), 32'd1);
    step(1, 3, 0);
    chk("t2_err_pulse_one_cycle", 32'(err_pulse), 32'd0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 2, 0);
    chk("t2_relocked", 32'(locked), 32'd1);

    // 3: enable low freezes everything
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 2, 0);
    step(1, 3, 0);
    chk("t3_still_locked", 32'(locked), 32'd1);
    chk("t3_no_err", 32'(err_count), 32'd1);

    // 4: asynchronous reset between edges
    @(posedge clk);
    #50 rst = 1'b1;
    #5 check_zero("t4_async");
    model_reset();
    #20 rst = 1'b0;
    step(1, 0, 0);
    chk("t4_restart_not_locked", 32'(locked), 32'd0);
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 3, 0);
    step(1, 0, 0);
    chk("t4_relocked", 32'(locked), 32'd1);

    // 5: set beats clear, then clear alone
    step(1, 2, 1);
    chk("t5_set_wins", 32'(err_sticky), 32'd1);
    step(0, 1, 1);
    chk("t5_cleared", 32'(err_sticky), 32'd0);

    // 6: saturation of the narrow wrap counter
    step(1, 3, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 2, 0);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, (3 + i) % 4, 0);
      if (wrap_pulse2) npulse++;
    end
    chk("t6_wrap_count2_sat", 32'(wrap_count2), 32'd3);
    chk("t6_pulses", 32'(npulse), 32'd5);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 99) < 90);
      clr = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 85) c = (m_prev + 1) % 4;
      else c = int'($urandom_range(0, 3));
      step(e, c, clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
